// File: rtl/bench_report_pkg.sv
// Shared constants, FSM states and frame layout for the
// benchmark result UART reporter.
package bench_report_pkg;

  localparam int FRAME_LEN = 33;
  localparam int CSUM_IDX  = 32;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  localparam int IDX_HDR = 0;
  localparam int IDX_WIN = 1;
  localparam int IDX_OPS = 2;
  localparam int IDX_T0  = 4;
  localparam int IDX_T4  = 20;
  localparam int IDX_TOT = 24;
  localparam int IDX_RUN = 28;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    FIN
  } state_e;

  // Byte k (0 = most significant) of a 32-bit word.
  function automatic logic [7:0] be_byte(
    input logic [31:0] w,
    input logic [1:0]  k
  );
    logic [31:0] s;
    s = w << {k, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first,
// stop bit, each CLKS_PER_BIT cycles long.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sh_q, sh_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (tx_start) begin
        sh_d   = {1'b1, tx_data, 1'b0};
        busy_d = 1'b1;
        baud_d = '0;
        bit_d  = '0;
      end
    end else if (baud_q == BAUD_MAX) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        // Shift in ones so the line rests high after the stop bit.
        sh_d  = {1'b1, sh_q[9:1]};
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign txd     = sh_q[0];
  assign tx_done = done_q;
  assign tx_busy = busy_q;

endmodule

// File: rtl/bench_report_uart.sv
// Snapshots the benchmark result bus on done rising and
// streams it as a 33-byte XOR-checked UART frame.
module bench_report_uart
  import bench_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter logic [7:0] HEADER_BYTE = HEADER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [2:0]  winner_code,
  input  logic [15:0] ops_per_condition,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  input  logic [31:0] t_cond4,
  input  logic [31:0] t_total,
  input  logic [31:0] t_runtime,
  output logic        uart_txd,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        overrun
);

  localparam logic [5:0] CSUM_B = 6'(CSUM_IDX);
  localparam logic [5:0] LAST_B = 6'(FRAME_LEN - 1);
  localparam logic [3:0] W_HDR  = 4'(IDX_HDR / 4);
  localparam logic [3:0] W_T0   = 4'(IDX_T0 / 4);
  localparam logic [3:0] W_T4   = 4'(IDX_T4 / 4);
  localparam logic [3:0] W_TOT  = 4'(IDX_TOT / 4);
  localparam logic [3:0] W_RUN  = 4'(IDX_RUN / 4);
  localparam logic [1:0] B_WIN  = 2'(IDX_WIN % 4);
  localparam logic [1:0] B_OPS  = 2'(IDX_OPS % 4);

  state_e state_q, state_d;
  logic       done_d_q;
  logic [5:0] byte_idx_q, byte_idx_d;
  logic [7:0] csum_q, csum_d;
  logic       busy_q, busy_d;
  logic [15:0] frames_sent_q, frames_sent_d;
  logic       overrun_q, overrun_d;

  logic [2:0]       win_q, win_d;
  logic [15:0]      ops_q, ops_d;
  logic [4:0][31:0] tc_q, tc_d;
  logic [31:0]      tot_q, tot_d;
  logic [31:0]      run_q, run_d;

  logic       trig;
  logic       tx_start, tx_done, tx_busy, txd;
  logic [7:0] cur_byte;
  logic [3:0] wsel;
  logic [1:0] bsel;
  logic [2:0] tsel;

  assign trig = done & ~done_d_q;
  assign wsel = byte_idx_q[5:2];
  assign bsel = byte_idx_q[1:0];
  assign tsel = 3'(wsel - W_T0);

  // Frame words are 4 bytes wide; word 0 holds header/winner/ops.
  always_comb begin
    cur_byte = csum_q;
    unique case (1'b1)
      (wsel == W_HDR): begin
        unique case (1'b1)
          (bsel == B_WIN):        cur_byte = {5'b0, win_q};
          (bsel == B_OPS):        cur_byte = ops_q[15:8];
          (bsel == B_OPS + 2'd1): cur_byte = ops_q[7:0];
          default:                cur_byte = HEADER_BYTE;
        endcase
      end
      (wsel >= W_T0 && wsel <= W_T4): cur_byte = be_byte(tc_q[tsel], bsel);
      (wsel == W_TOT): cur_byte = be_byte(tot_q, bsel);
      (wsel == W_RUN): cur_byte = be_byte(run_q, bsel);
      default:         cur_byte = csum_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    csum_d        = csum_q;
    busy_d        = busy_q;
    frames_sent_d = frames_sent_q;
    overrun_d     = overrun_q;
    win_d         = win_q;
    ops_d         = ops_q;
    tc_d          = tc_q;
    tot_d         = tot_q;
    run_d         = run_q;
    tx_start      = 1'b0;
    if (trig && state_q != IDLE) overrun_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          win_d      = winner_code;
          ops_d      = ops_per_condition;
          tc_d       = {t_cond4, t_cond3, t_cond2, t_cond1, t_cond0};
          tot_d      = t_total;
          run_d      = t_runtime;
          busy_d     = 1'b1;
          byte_idx_d = '0;
          csum_d     = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          if (byte_idx_q != CSUM_B) csum_d = csum_q ^ cur_byte;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_done) begin
          if (byte_idx_q == LAST_B) begin
            state_d = FIN;
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
            state_d    = LOAD;
          end
        end
      end
      FIN: begin
        frames_sent_d = frames_sent_q + 16'd1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      done_d_q      <= 1'b0;
      byte_idx_q    <= '0;
      csum_q        <= '0;
      busy_q        <= 1'b0;
      frames_sent_q <= '0;
      overrun_q     <= 1'b0;
      win_q         <= '0;
      ops_q         <= '0;
      tc_q          <= '0;
      tot_q         <= '0;
      run_q         <= '0;
    end else begin
      state_q       <= state_d;
      done_d_q      <= done;
      byte_idx_q    <= byte_idx_d;
      csum_q        <= csum_d;
      busy_q        <= busy_d;
      frames_sent_q <= frames_sent_d;
      overrun_q     <= overrun_d;
      win_q         <= win_d;
      ops_q         <= ops_d;
      tc_q          <= tc_d;
      tot_q         <= tot_d;
      run_q         <= run_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (cur_byte),
    .txd     (txd),
    .tx_done (tx_done),
    .tx_busy (tx_busy)
  );

  assign uart_txd    = txd;
  assign busy        = busy_q;
  assign frames_sent = frames_sent_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_bench_report_uart.sv
// Directed/randomized bench for bench_report_uart with a
// UART receiver and a field-level frame model.
module tb_bench_report_uart;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done = 1'b0;
  logic [2:0]  win = '0;
  logic [15:0] ops = '0;
  logic [31:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic [31:0] tt = '0, tr = '0;
  logic        uart_txd, busy, overrun;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  bench_report_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .done             (done),
    .winner_code      (win),
    .ops_per_condition(ops),
    .t_cond0          (c0),
    .t_cond1          (c1),
    .t_cond2          (c2),
    .t_cond3          (c3),
    .t_cond4          (c4),
    .t_total          (tt),
    .t_runtime        (tr),
    .uart_txd         (uart_txd),
    .busy             (busy),
    .frames_sent      (frames_sent),
    .overrun          (overrun)
  );

  int n_pass = 0;
  int n_total = 0;
  int ferr = 0;
  int exp_frames = 0;
  logic [7:0] rxq[$];
  time rxt[$];
  logic [7:0] exp_f[33];
  time t_trig;

  // Receiver: sample each bit near its middle using the clock.
  always begin
    time ts;
    logic [7:0] b;
    logic sb;
    @(negedge uart_txd);
    ts = $time;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_txd;
    end
    repeat (CPB) @(negedge clk);
    sb = uart_txd;
    if (rst_n) begin
      if (!sb) ferr++;
      rxq.push_back(b);
      rxt.push_back(ts);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void build();
    logic [31:0] words[7];
    words = '{c0, c1, c2, c3, c4, tt, tr};
    exp_f[0] = 8'hA5;
    exp_f[1] = {5'b0, win};
    exp_f[2] = ops[15:8];
    exp_f[3] = ops[7:0];
    for (int k = 0; k < 7; k++)
      for (int b = 0; b < 4; b++)
        exp_f[4 + 4 * k + b] = 8'(words[k] >> (24 - 8 * b));
    exp_f[32] = 8'h00;
    for (int i = 0; i < 32; i++) exp_f[32] ^= exp_f[i];
  endfunction

  task automatic rand_inputs();
    win = 3'($urandom);
    ops = 16'($urandom);
    c0 = $urandom; c1 = $urandom; c2 = $urandom;
    c3 = $urandom; c4 = $urandom;
    tt = $urandom; tr = $urandom;
  endtask

  task automatic zero_inputs();
    win = '0; ops = '0;
    c0 = '0; c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    tt = '0; tr = '0;
  endtask

  task automatic trigger();
    @(negedge clk);
    build();
    done = 1'b1;
    t_trig = $time;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_bytes(input int cnt);
    int n;
    n = 0;
    while (rxq.size() < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("byte_wait", 32'(rxq.size() >= cnt), 1);
  endtask

  task automatic check_frame(input string tag);
    int len;
    chk({tag, "_nbytes"}, rxq.size(), 33);
    chk({tag, "_framing"}, ferr, 0);
    for (int i = 0; i < 33 && i < rxq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rxq[i], exp_f[i]);
    if (rxq.size() == 33) begin
      chk({tag, "_start_lat"}, 32'((rxt[0] - t_trig) <= 35), 1);
      len = int'((rxt[32] - rxt[0]) / 10) + 10 * CPB;
      chk({tag, "_len"}, 32'(len >= 330 * CPB && len <= 330 * CPB + 66), 1);
    end
    rxq.delete();
    rxt.delete();
    ferr = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frames", frames_sent, 16'h0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Fixed frame with done held high for 5000 cycles.
    win = 3'd3; ops = 16'h0100;
    c0 = 32'h11111111; c1 = 32'h22222222; c2 = 32'h33333333;
    c3 = 32'h44444444; c4 = 32'h55555555;
    tt = 32'hDEADBEEF; tr = 32'h00001234;
    trigger();
    @(negedge clk);
    chk("single_busy_hi", busy, 1'b1);
    repeat (5000) @(negedge clk);
    exp_frames++;
    chk("single_busy_lo", busy, 1'b0);
    check_frame("single");
    chk("single_frames", frames_sent, 16'(exp_frames));
    chk("single_overrun", overrun, 1'b0);
    done = 1'b0;

    // Inputs cleared two cycles after the trigger.
    rand_inputs();
    trigger();
    repeat (2) @(negedge clk);
    zero_inputs();
    done = 1'b0;
    wait_idle("iso_idle");
    exp_frames++;
    check_frame("iso");
    chk("iso_frames", frames_sent, 16'(exp_frames));

    // Retrigger with fresh data during byte 10.
    rand_inputs();
    trigger();
    repeat (2) @(negedge clk);
    done = 1'b0;
    wait_bytes(10);
    rand_inputs();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_idle("mid_idle");
    repeat (300) @(negedge clk);
    exp_frames++;
    check_frame("mid");
    chk("mid_overrun", overrun, 1'b1);
    chk("mid_frames", frames_sent, 16'(exp_frames));

    // Asynchronous reset while byte 20 is on the line.
    rand_inputs();
    trigger();
    repeat (2) @(negedge clk);
    done = 1'b0;
    wait_bytes(20);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_txd", uart_txd, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_frames", frames_sent, 16'h0);
    chk("arst_overrun", overrun, 1'b0);
    exp_frames = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rxq.delete();
    rxt.delete();
    ferr = 0;
    repeat (200) @(negedge clk);
    chk("arst_no_resume", rxq.size(), 0);
    chk("arst_idle_txd", uart_txd, 1'b1);

    rand_inputs();
    trigger();
    repeat (2) @(negedge clk);
    done = 1'b0;
    wait_idle("post_idle");
    exp_frames++;
    check_frame("post");
    chk("post_frames", frames_sent, 16'(exp_frames));

    // Counter wrap.
    @(negedge clk);
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    @(negedge clk);
    chk("wrap_pre", frames_sent, 16'hFFFF);
    rand_inputs();
    trigger();
    repeat (2) @(negedge clk);
    done = 1'b0;
    wait_idle("wrap_idle");
    check_frame("wrap");
    chk("wrap_frames", frames_sent, 16'h0000);
    chk("wrap_overrun", overrun, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bench_report_uart.md
Name: bench_report_uart

Overview:
- Downstream consumer of the benchmark engine's result bus.
- On each completed run (rising edge of done), it snapshots:
  - all five condition timings,
  - total and runtime counters,
  - ops_per_condition,
  - winner_code.
- It then serialises them as one fixed 33-byte framed packet over a UART 8N1 TX line.
- Sits beside the LED remap at board top level, so results can be logged on a host PC.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per UART bit (125 MHz / 115200); legal range 2..65535.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- done  in  1  engine done level; a 0->1 transition triggers a report
- winner_code  in  3  winning condition index
- ops_per_condition  in  16  ops per condition
- t_cond0 .. t_cond4  in  32 each  per-condition cycle counts
- t_total  in  32  total cycle count
- t_runtime  in  32  runtime cycle count
- uart_txd  out  1  serial output, idle high
- busy  out  1  high from trigger until the last stop bit completes
- frames_sent  out  16  count of completed frames, wraps 16'hFFFF -> 0
- overrun  out  1  sticky: a trigger arrived while busy

Behaviour:
- Reset values (async, rst_n=0): uart_txd=1, busy=0, frames_sent=0, overrun=0, FSM=IDLE, done_d=0, snapshot regs=0.
- Trigger detection:
  - trig = done & ~done_d, with done_d a registered copy of done.
  - done held high produces exactly one trigger.
- Snapshot timing:
  - In IDLE, on trig all inputs are registered in the same edge; later input changes do not affect the frame.
  - busy rises on that edge.
- Frame byte map, multi-byte fields MSB first:
  - B0 = HEADER_BYTE
  - B1 = {5'b0, winner_code}
  - B2..B3 = ops_per_condition
  - B4..B7 = t_cond0
  - B8..B11 = t_cond1
  - B12..B15 = t_cond2
  - B16..B19 = t_cond3
  - B20..B23 = t_cond4
  - B24..B27 = t_total
  - B28..B31 = t_runtime
  - B32 = XOR of B0..B31
- FSM states:
  - IDLE: on trig -> LOAD, byte_idx=0, csum=0.
  - LOAD: select byte (B32 = csum), pulse tx_start to the byte transmitter, csum ^= byte (except for B32) -> SEND.
  - SEND: wait for tx_done. If byte_idx==32 -> FIN; else byte_idx++ -> LOAD.
  - FIN: frames_sent++, busy=0 -> IDLE.
- Bit timing:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - The start bit of byte k+1 begins within 2 cycles after the stop bit of byte k ends.
  - A frame therefore lasts 330*CLKS_PER_BIT + at most 66 cycles.
  - uart_txd falls at most 3 cycles after the edge that samples trig.
- Overrun:
  - trig while busy is ignored for data, and sets overrun=1.
  - overrun clears only on reset.
- Reset mid-frame: uart_txd returns high immediately (async); no partial frame resumes after reset release.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - byte_idx is 6 bits.
  - frames_sent wraps modulo 2^16 with no saturation.

Decomposition:
- Shared package bench_report_pkg holds:
  - FRAME_LEN=33, CSUM_IDX=32, default HEADER_BYTE;
  - FSM state enum {IDLE, LOAD, SEND, FIN};
  - the byte-index-to-field localparams.
- One sub-module, uart_tx_byte (params CLKS_PER_BIT):
  - inputs clk, rst_n, tx_start, tx_data[7:0];
  - outputs txd, tx_done (1-cycle pulse at end of stop bit), tx_busy.
- Frame sequencing and snapshot logic stay in bench_report_uart.

Test Plan (CLKS_PER_BIT=4, UART receiver model on uart_txd):
- Single report:
  - Stimulus: winner=3, ops=16'h0100, t_cond0..4=32'h11111111..32'h55555555, t_total=32'hDEADBEEF, t_runtime=32'h00001234; done rises.
  - Required: 33 bytes, exactly A5 03 01 00 11 11 11 11 ... DE AD BE EF 00 00 12 34 then the XOR byte; frames_sent=1; busy low afterwards.
  - Required: frame length between 1320 and 1386 cycles.
- Snapshot isolation:
  - Stimulus: change all inputs to 0 two cycles after the trigger.
  - Required: the frame still carries the original values.
- done held high 5000 cycles:
  - Required: exactly one frame, overrun=0.
- Second trigger mid-frame:
  - Stimulus: done toggles 0->1 at byte 10.
  - Required: the frame completes unchanged, overrun=1, frames_sent=1, no second frame.
- Async reset at byte 20:
  - Required: uart_txd=1 and busy=0 within the same cycle, frames_sent=0, overrun=0.
  - Required: a new trigger after reset yields a complete correct frame.
- Wrap:
  - Stimulus: force frames_sent=16'hFFFF, then send one frame.
  - Required: frames_sent=0.
